// File: rtl/count_updown.sv
// count_updown: synchronous up/down counter with a registered carry/borrow
// pulse. The counter wraps modulo 2^WIDTH. c_out rises for one clock in the
// same cycle that q shows the wrapped value.
module count_updown #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  input  logic             en,
  output logic             c_out,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             step_up;
  logic             step_down;
  logic [WIDTH-1:0] next_q;
  logic             next_c;

  // Decode the step direction; up and down together count as idle, so q holds.
  always_comb begin
    step_up   = en & up & ~down;
    step_down = en & down & ~up;
    next_q    = q;
    next_c    = 1'b0;
    if (step_up) begin
      next_q = q + ONE;
      next_c = (q == ALL_ONES);
    end else if (step_down) begin
      next_q = q - ONE;
      next_c = (q == ZERO);
    end
  end

  // Register the count and the wrap pulse. Reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      c_out <= 1'b0;
    end else begin
      q     <= next_q;
      c_out <= next_c;
    end
  end

endmodule

// File: tb/tb_count_updown.sv
// tb_count_updown: directed vectors for count_updown. Each vector carries the
// hand-computed q/c_out expected after the edge that samples it. A separate
// monitor pops expectations and compares them once per clock.
module tb_count_updown;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             up;
  logic             down;
  logic             en;
  logic             c_out;
  logic [WIDTH-1:0] q;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             c;
    string            name;
  } expect_t;

  expect_t exp_queue[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  bit      stim_done = 1'b0;

  count_updown #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .up    (up),
    .down  (down),
    .en    (en),
    .c_out (c_out),
    .q     (q)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one vector away from the active edge and queue its expected result.
  task automatic apply_stimulus(input logic r, input logic e, input logic u,
                                input logic d, input logic [WIDTH-1:0] eq,
                                input logic ec, input string name);
    expect_t item;
    @(negedge clk);
    rst  = r;
    en   = e;
    up   = u;
    down = d;
    item.q    = eq;
    item.c    = ec;
    item.name = name;
    exp_queue.push_back(item);
  endtask

  // Compare one DUT sample against a queued expectation.
  task automatic check_output(input expect_t item);
    n_checks++;
    if (q !== item.q || c_out !== item.c) begin
      n_fail++;
      $display("[TB] FAIL %s: got q=%0d c_out=%b, expected q=%0d c_out=%b",
               item.name, q, c_out, item.q, item.c);
    end
  endtask

  // Monitor: one result appears per edge, sampled 1 unit after it.
  initial begin
    expect_t item;
    forever begin
      @(posedge clk);
      #1;
      if (exp_queue.size() > 0) begin
        item = exp_queue.pop_front();
        check_output(item);
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b0; down = 1'b0;

    // Reset with up/en asserted, then count up five.
    apply_stimulus(1, 1, 1, 0, 8'd0, 0, "reset_0");
    apply_stimulus(1, 1, 1, 0, 8'd0, 0, "reset_1");
    for (int i = 1; i <= 5; i++)
      apply_stimulus(0, 1, 1, 0, WIDTH'(i), 0, "count_to_5");

    // Preload to 254, then wrap upward.
    for (int i = 6; i <= 254; i++)
      apply_stimulus(0, 1, 1, 0, WIDTH'(i), 0, "preload_254");
    apply_stimulus(0, 1, 1, 0, 8'd255, 0, "up_to_255");
    apply_stimulus(0, 1, 1, 0, 8'd0,   1, "up_wrap");

    // Step to 1, then wrap downward.
    apply_stimulus(0, 1, 1, 0, 8'd1,   0, "up_to_1");
    apply_stimulus(0, 1, 0, 1, 8'd0,   0, "down_to_0");
    apply_stimulus(0, 1, 0, 1, 8'd255, 1, "down_wrap");

    // Wrap up again and count to 10.
    apply_stimulus(0, 1, 1, 0, 8'd0, 1, "up_wrap_2");
    for (int i = 1; i <= 10; i++)
      apply_stimulus(0, 1, 1, 0, WIDTH'(i), 0, "count_to_10");

    // Conflict and idle both hold.
    for (int i = 0; i < 3; i++)
      apply_stimulus(0, 1, 1, 1, 8'd10, 0, "conflict_hold");
    apply_stimulus(0, 1, 0, 0, 8'd10, 0, "idle_hold");

    // Count to 20, then hold with enable low.
    for (int i = 11; i <= 20; i++)
      apply_stimulus(0, 1, 1, 0, WIDTH'(i), 0, "count_to_20");
    for (int i = 0; i < 4; i++)
      apply_stimulus(0, 0, 1, 0, 8'd20, 0, "enable_low_hold");
    apply_stimulus(0, 1, 1, 0, 8'd21, 0, "enable_resume");

    // Count to 100, then reset mid-run and resume.
    for (int i = 22; i <= 100; i++)
      apply_stimulus(0, 1, 1, 0, WIDTH'(i), 0, "count_to_100");
    apply_stimulus(1, 1, 1, 0, 8'd0, 0, "midrun_reset");
    for (int i = 1; i <= 3; i++)
      apply_stimulus(0, 1, 1, 0, WIDTH'(i), 0, "resume_after_reset");

    // Reset on the cycle after a wrap must clear c_out.
    apply_stimulus(0, 1, 0, 1, 8'd2,   0, "down_to_2");
    apply_stimulus(0, 1, 0, 1, 8'd1,   0, "down_to_1");
    apply_stimulus(0, 1, 0, 1, 8'd0,   0, "down_to_0b");
    apply_stimulus(0, 1, 0, 1, 8'd255, 1, "down_wrap_2");
    apply_stimulus(1, 1, 0, 1, 8'd0,   0, "reset_after_wrap");

    @(negedge clk);
    en = 1'b0; up = 1'b0; down = 1'b0; rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    stim_done = 1'b1;

    // Every queued expectation must have been consumed.
    n_checks++;
    if (exp_queue.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_queue.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    if (!stim_done) begin
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] timeout");
    end
  end

endmodule
